// File: rtl/router_switch_arbiter_if.sv
// Bundle of FIFO-head, routing-code and output-slot signals around the switch arbiter.
// The arbiter uses the slave modport; the FIFO/routing side and downstream use master.
interface router_switch_arbiter_if #(
    parameter int unsigned DATA_W = 40
);
    logic [DATA_W-1:0] din_x, din_y, din_local;
    logic              empty_x, empty_y, empty_local;
    logic [1:0]        route_x, route_y, route_local;
    logic              rd_en_x, rd_en_y, rd_en_local;
    logic [DATA_W-1:0] dout_x, dout_y, dout_local;
    logic              valid_x, valid_y, valid_local;
    logic              ready_x, ready_y, ready_local;

    modport master (
        output din_x, din_y, din_local,
        output empty_x, empty_y, empty_local,
        output route_x, route_y, route_local,
        output ready_x, ready_y, ready_local,
        input  rd_en_x, rd_en_y, rd_en_local,
        input  dout_x, dout_y, dout_local,
        input  valid_x, valid_y, valid_local
    );

    modport slave (
        input  din_x, din_y, din_local,
        input  empty_x, empty_y, empty_local,
        input  route_x, route_y, route_local,
        input  ready_x, ready_y, ready_local,
        output rd_en_x, rd_en_y, rd_en_local,
        output dout_x, dout_y, dout_local,
        output valid_x, valid_y, valid_local
    );
endinterface

// File: rtl/router_switch_arbiter.sv
// Output-side switch: per-port round-robin over X/Y/Local FIFO heads into registered slots.
// ROUTER_SW_DROP_CNT_EN adds a saturating 8-bit drop_cnt port counting route-00 discards.
module router_switch_arbiter #(
    parameter int unsigned DATA_W = 40
) (
    input  logic clk,
    input  logic rst_n,
    router_switch_arbiter_if.slave bus
`ifdef ROUTER_SW_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);
    typedef enum logic [1:0] {SEL_X = 2'd0, SEL_Y = 2'd1, SEL_L = 2'd2} sel_e;
    localparam int unsigned N = 3;

    logic [DATA_W-1:0] din [N];
    logic [1:0]        route [N];
    logic [N-1:0]      empty, ready;

    logic [1:0]        blk_q [N], blk_d [N];
    sel_e              ptr_q [N], ptr_d [N];
    logic [DATA_W-1:0] dout_q [N], dout_d [N];
    logic [N-1:0]      valid_q, valid_d;
    logic [N-1:0]      elig, drop, rd_en;
    logic              found;
    logic [1:0]        cand;

    assign din[0]   = bus.din_x;
    assign din[1]   = bus.din_y;
    assign din[2]   = bus.din_local;
    assign route[0] = bus.route_x;
    assign route[1] = bus.route_y;
    assign route[2] = bus.route_local;
    assign empty    = {bus.empty_local, bus.empty_y, bus.empty_x};
    assign ready    = {bus.ready_local, bus.ready_y, bus.ready_x};

    assign bus.rd_en_x     = rd_en[0];
    assign bus.rd_en_y     = rd_en[1];
    assign bus.rd_en_local = rd_en[2];
    assign bus.dout_x      = dout_q[0];
    assign bus.dout_y      = dout_q[1];
    assign bus.dout_local  = dout_q[2];
    assign bus.valid_x     = valid_q[0];
    assign bus.valid_y     = valid_q[1];
    assign bus.valid_local = valid_q[2];

    always_comb begin
        elig    = '0;
        drop    = '0;
        rd_en   = '0;
        valid_d = valid_q;
        found   = 1'b0;
        cand    = 2'd0;
        for (int unsigned i = 0; i < N; i++) begin
            dout_d[i] = dout_q[i];
            ptr_d[i]  = ptr_q[i];
        end
        // rst_n is active-high: inputs are only eligible while it is low
        for (int unsigned i = 0; i < N; i++) begin
            elig[i]  = !rst_n && !empty[i] && (blk_q[i] == 2'd0);
            drop[i]  = elig[i] && (route[i] == 2'b00);
            rd_en[i] = drop[i];
        end
        for (int unsigned o = 0; o < N; o++) begin
            if (valid_q[o] && ready[o]) begin
                valid_d[o] = 1'b0;
            end
            found = 1'b0;
            cand  = ptr_q[o];
            if (!valid_q[o] || ready[o]) begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (!found && elig[cand] && (route[cand] == 2'(o + 1))) begin
                        found       = 1'b1;
                        rd_en[cand] = 1'b1;
                        dout_d[o]   = din[cand];
                        valid_d[o]  = 1'b1;
                        ptr_d[o]    = (cand == 2'd2) ? SEL_X : sel_e'(cand + 2'd1);
                    end
                    cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
                end
            end
        end
        // Two idle cycles after a pop let the FIFO head and routing register catch up
        for (int unsigned i = 0; i < N; i++) begin
            if (rd_en[i]) begin
                blk_d[i] = 2'd2;
            end else if (blk_q[i] != 2'd0) begin
                blk_d[i] = blk_q[i] - 2'd1;
            end else begin
                blk_d[i] = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                blk_q[i]  <= 2'd0;
                ptr_q[i]  <= SEL_X;
                dout_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned i = 0; i < N; i++) begin
                blk_q[i]  <= blk_d[i];
                ptr_q[i]  <= ptr_d[i];
                dout_q[i] <= dout_d[i];
            end
        end
    end

`ifdef ROUTER_SW_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [9:0] drop_sum;

    always_comb begin
        drop_sum   = {2'b00, drop_cnt_q} + 10'(drop[0]) + 10'(drop[1]) + 10'(drop[2]);
        drop_cnt_d = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_router_switch_arbiter.sv
// Directed bench for router_switch_arbiter: FIFO queues feed the DUT, a queue-based
// model predicts rd_en/valid/dout (and drop_cnt) every cycle, plus literal spot checks.
module tb_router_switch_arbiter;
    localparam int unsigned DW = 40;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    rt;
    } pkt_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    router_switch_arbiter_if #(.DATA_W(DW)) bus ();
`ifdef ROUTER_SW_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    router_switch_arbiter #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ROUTER_SW_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    pkt_t        fifo [3][$];
    logic [2:0]  rdy;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // model state: slots, rotation pointers, earliest cycle each input may pop again
    int            cyc;
    int            next_ok [3];
    int            mptr [3];
    logic [2:0]    mvalid;
    logic [DW-1:0] mdout [3];
    int            mdrops;
    logic [2:0]    e_rd;
    int            gnt_src [3];
    int            ndrop;

    logic [2:0]    obs_rd, obs_valid;
    logic [DW-1:0] obs_dout [3];
    logic [7:0]    obs_drop;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] d, input logic [1:0] r);
        pkt_t p;
        p.data = d;
        p.rt   = r;
        fifo[i].push_back(p);
    endtask

    function automatic pkt_t head(input int i);
        pkt_t p;
        p.data = '0;
        p.rt   = 2'b00;
        if (fifo[i].size() > 0) p = fifo[i][0];
        return p;
    endfunction

    task automatic drive();
        pkt_t h0, h1, h2;
        h0 = head(0);
        h1 = head(1);
        h2 = head(2);
        bus.din_x       = h0.data;
        bus.route_x     = h0.rt;
        bus.empty_x     = (fifo[0].size() == 0);
        bus.din_y       = h1.data;
        bus.route_y     = h1.rt;
        bus.empty_y     = (fifo[1].size() == 0);
        bus.din_local   = h2.data;
        bus.route_local = h2.rt;
        bus.empty_local = (fifo[2].size() == 0);
        bus.ready_x     = rdy[0];
        bus.ready_y     = rdy[1];
        bus.ready_local = rdy[2];
    endtask

    task automatic model_comb();
        bit elig [3];
        int i;
        e_rd  = '0;
        ndrop = 0;
        for (int n = 0; n < 3; n++) begin
            elig[n] = (rst_n == 1'b0) && (fifo[n].size() > 0) && (cyc >= next_ok[n]);
            if (elig[n] && fifo[n][0].rt == 2'b00) begin
                e_rd[n] = 1'b1;
                ndrop++;
            end
        end
        for (int o = 0; o < 3; o++) begin
            gnt_src[o] = -1;
            if (!mvalid[o] || rdy[o]) begin
                for (int k = 0; k < 3; k++) begin
                    i = (mptr[o] + k) % 3;
                    if (gnt_src[o] < 0 && elig[i] && int'(fifo[i][0].rt) == o + 1) begin
                        gnt_src[o] = i;
                        e_rd[i]    = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_seq();
        if (rst_n) begin
            mvalid = '0;
            mdrops = 0;
            for (int n = 0; n < 3; n++) begin
                mdout[n]   = '0;
                mptr[n]    = 0;
                next_ok[n] = 0;
            end
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (gnt_src[o] >= 0) begin
                    mdout[o]  = fifo[gnt_src[o]][0].data;
                    mvalid[o] = 1'b1;
                    mptr[o]   = (gnt_src[o] + 1) % 3;
                end else if (mvalid[o] && rdy[o]) begin
                    mvalid[o] = 1'b0;
                end
            end
            for (int n = 0; n < 3; n++) begin
                if (e_rd[n]) begin
                    next_ok[n] = cyc + 3;
                    void'(fifo[n].pop_front());
                end
            end
            mdrops = (mdrops + ndrop > 255) ? 255 : mdrops + ndrop;
        end
        cyc++;
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        obs_rd      = {bus.rd_en_local, bus.rd_en_y, bus.rd_en_x};
        obs_valid   = {bus.valid_local, bus.valid_y, bus.valid_x};
        obs_dout[0] = bus.dout_x;
        obs_dout[1] = bus.dout_y;
        obs_dout[2] = bus.dout_local;
`ifdef ROUTER_SW_DROP_CNT_EN
        obs_drop = drop_cnt;
`else
        obs_drop = 8'h00;
`endif
        model_comb();
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("rd_en[%0d]", n), DW'(obs_rd[n]), DW'(e_rd[n]));
            chk($sformatf("valid[%0d]", n), DW'(obs_valid[n]), DW'(mvalid[n]));
            chk($sformatf("dout[%0d]", n), obs_dout[n], mdout[n]);
        end
`ifdef ROUTER_SW_DROP_CNT_EN
        chk("drop_cnt", DW'(obs_drop), DW'(mdrops));
`endif
        @(posedge clk);
        #1;
        model_seq();
    endtask

    initial begin
        logic [2:0] order [4];
        int         run, best, ng;
        logic [8:0] drop_seen;

        rst_n = 1'b1;
        rdy   = '1;
        cyc   = 0;
        ndrop = 0;
        model_seq();
        cyc = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;

        // reset state
        cycle();
        chk("reset_valid", DW'(obs_valid), '0);
        chk("reset_dout_x", obs_dout[0], '0);
        rst_n = 1'b0;

        // single packet X -> X
        push(0, 40'h4_00000_1234, 2'b01);
        cycle();
        chk("single_rd", DW'(obs_rd), DW'(3'b001));
        cycle();
        chk("single_valid", DW'(obs_valid[0]), DW'(1'b1));
        chk("single_dout", obs_dout[0], 40'h4_00000_1234);
        chk("single_rd_once", DW'(obs_rd), '0);
        cycle();
        chk("single_drain", DW'(obs_valid[0]), '0);

        // contention: all three inputs to Y
        for (int k = 0; k < 4; k++) begin
            push(0, {4'b0110, 36'(k)}, 2'b10);
            push(1, {4'b1010, 36'(k)}, 2'b10);
            push(2, {4'b1110, 36'(k)}, 2'b10);
        end
        run  = 0;
        best = 0;
        ng   = 0;
        for (int c = 0; c < 15; c++) begin
            cycle();
            if (obs_rd != 3'b000 && ng < 4) begin
                order[ng] = obs_rd;
                ng++;
            end
            run  = obs_valid[1] ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        chk("contention_order0", DW'(order[0]), DW'(3'b001));
        chk("contention_order1", DW'(order[1]), DW'(3'b010));
        chk("contention_order2", DW'(order[2]), DW'(3'b100));
        chk("contention_order3", DW'(order[3]), DW'(3'b001));
        chk("contention_valid_run", DW'(best >= 3), DW'(1'b1));

        // back-pressure on Local
        rdy[2] = 1'b0;
        push(0, 40'h7_AAAAA_0001, 2'b11);
        push(1, 40'hB_BBBBB_0002, 2'b11);
        cycle();
        chk("bp_first_grant", DW'(obs_rd), DW'(3'b001));
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("bp_no_rd", DW'(obs_rd), '0);
            chk("bp_dout_stable", obs_dout[2], 40'h7_AAAAA_0001);
        end
        rdy[2] = 1'b1;
        cycle();
        chk("bp_release_grant", DW'(obs_rd), DW'(3'b010));
        cycle();
        chk("bp_no_bubble", DW'(obs_valid[2]), DW'(1'b1));
        chk("bp_second_dout", obs_dout[2], 40'hB_BBBBB_0002);
        cycle();

        // drops on Y
        for (int k = 0; k < 3; k++) push(1, {4'b1000, 36'(k)}, 2'b00);
        drop_seen = '0;
        for (int c = 0; c < 9; c++) begin
            cycle();
            drop_seen[c] = obs_rd[1];
            chk("drop_no_load", DW'(obs_valid), '0);
        end
        chk("drop_timing", DW'(drop_seen), DW'(9'b001_001_001));
`ifdef ROUTER_SW_DROP_CNT_EN
        chk("drop_cnt_3", DW'(obs_drop), DW'(8'd3));
`endif

        // saturation: 300 drops
        for (int k = 0; k < 100; k++) begin
            push(0, DW'(k), 2'b00);
            push(1, DW'(k), 2'b00);
            push(2, DW'(k), 2'b00);
        end
        for (int c = 0; c < 302; c++) cycle();
`ifdef ROUTER_SW_DROP_CNT_EN
        chk("drop_cnt_sat", DW'(obs_drop), DW'(8'd255));
`endif

        // mid-operation reset with all slots full
        rdy = '0;
        push(0, 40'h5_11111_0001, 2'b01);
        push(1, 40'h9_22222_0002, 2'b10);
        push(2, 40'hD_33333_0003, 2'b11);
        cycle();
        chk("mr_parallel", DW'(obs_rd), DW'(3'b111));
        cycle();
        chk("mr_all_valid", DW'(obs_valid), DW'(3'b111));
        push(0, 40'h4_44444_0004, 2'b01);
        push(1, 40'h8_55555_0005, 2'b01);
        push(2, 40'hC_66666_0006, 2'b00);
        rst_n = 1'b1;
        cycle();
        cycle();
        chk("mr_valid_clr", DW'(obs_valid), '0);
        chk("mr_dout_clr", obs_dout[2], '0);
        chk("mr_rd_forced", DW'(obs_rd), '0);
        rst_n = 1'b0;
        rdy   = '1;
        cycle();
        chk("mr_first_grant", DW'(obs_rd), DW'(3'b101));
        for (int c = 0; c < 6; c++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
